// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with single-word refill.
// Define ICACHE_STAT_EN to build the hit/miss lookup counters.
module icache #(
    parameter int ENTRIES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        addr_sgn,
    input  logic [31:0] addr,
    input  logic        flush,
    output logic        ins_sgn,
    output logic [31:0] ins,
    output logic        mc_req,
    output logic [31:0] mc_addr,
    input  logic        mc_done,
    input  logic [31:0] mc_data,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
    output logic [1:0]  dbg_state
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDX;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MISS    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_ins_sgn;
    logic [31:0]         r_ins;
    logic                r_mc_req;
    logic [31:0]         r_mc_addr;
    logic [ENTRIES-1:0]  r_valid;
    logic [TAGW-1:0]     r_tag  [ENTRIES];
    logic [31:0]         r_data [ENTRIES];

    state_t              w_state_nxt;
    logic                w_ins_sgn_nxt;
    logic [31:0]         w_ins_nxt;
    logic                w_mc_req_nxt;
    logic [31:0]         w_mc_addr_nxt;
    logic                w_fill;
    logic                w_hit;
    logic                w_miss;

    logic [IDX-1:0]      w_idx;
    logic [TAGW-1:0]     w_tag;
    logic [IDX-1:0]      w_fill_idx;
    logic [TAGW-1:0]     w_fill_tag;
    logic                w_hit_line;
    logic                w_accept;
    logic                w_unused_addr;

    assign w_idx         = addr[IDX+1:2];
    assign w_tag         = addr[31:IDX+2];
    // The outstanding miss address lives in mc_addr, which is stable until mc_done.
    assign w_fill_idx    = r_mc_addr[IDX+1:2];
    assign w_fill_tag    = r_mc_addr[31:IDX+2];
    assign w_hit_line    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_accept      = addr_sgn && !r_ins_sgn && !flush;
    assign w_unused_addr = ^addr[1:0];

    always_comb begin
        w_state_nxt   = r_state;
        w_ins_sgn_nxt = 1'b0;
        w_ins_nxt     = r_ins;
        w_mc_req_nxt  = r_mc_req;
        w_mc_addr_nxt = r_mc_addr;
        w_fill        = 1'b0;
        w_hit         = 1'b0;
        w_miss        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_hit_line) begin
                        w_hit         = 1'b1;
                        w_ins_nxt     = r_data[w_idx];
                        w_ins_sgn_nxt = 1'b1;
                    end else begin
                        w_miss        = 1'b1;
                        w_mc_req_nxt  = 1'b1;
                        w_mc_addr_nxt = addr;
                        w_state_nxt   = S_MISS;
                    end
                end
            end
            S_MISS: begin
                if (mc_done) begin
                    w_fill       = 1'b1;
                    w_mc_req_nxt = 1'b0;
                    w_state_nxt  = S_IDLE;
                    if (!flush) begin
                        w_ins_nxt     = mc_data;
                        w_ins_sgn_nxt = 1'b1;
                    end
                end else if (flush) begin
                    w_state_nxt = S_DISCARD;
                end
            end
            S_DISCARD: begin
                // The refill data is still correct, so the line is kept.
                if (mc_done) begin
                    w_fill       = 1'b1;
                    w_mc_req_nxt = 1'b0;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_mc_req_nxt = 1'b0;
            end
        endcase
        if (flush) begin
            w_ins_sgn_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ins_sgn <= 1'b0;
            r_ins     <= '0;
            r_mc_req  <= 1'b0;
            r_mc_addr <= '0;
            r_valid   <= '0;
        end else if (rdy) begin
            r_state   <= w_state_nxt;
            r_ins_sgn <= w_ins_sgn_nxt;
            r_ins     <= w_ins_nxt;
            r_mc_req  <= w_mc_req_nxt;
            r_mc_addr <= w_mc_addr_nxt;
            if (w_fill) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
        end else begin
            // A delivery due while frozen is dropped; fetch re-requests it.
            r_ins_sgn <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && w_fill) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= mc_data;
        end
    end

`ifdef ICACHE_STAT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (rdy) begin
            if (w_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_miss) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`else
    logic w_unused_stat;
    assign w_unused_stat = w_hit ^ w_miss;
    assign hit_cnt       = '0;
    assign miss_cnt      = '0;
`endif

    assign ins_sgn   = r_ins_sgn;
    assign ins       = r_ins;
    assign mc_req    = r_mc_req;
    assign mc_addr   = r_mc_addr;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a fetch driver pushes expected words into a queue,
// a negedge monitor pops them on every ins_sgn pulse, a responder models memory.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        addr_sgn;
    logic [31:0] addr;
    logic        flush;
    logic        ins_sgn;
    logic [31:0] ins;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic        mc_done;
    logic [31:0] mc_data;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
    logic [1:0]  dbg_state;

`ifdef ICACHE_STAT_EN
    localparam int STAT = 1;
`else
    localparam int STAT = 0;
`endif

    int          n_vec   = 0;
    int          n_err   = 0;
    int          refills = 0;
    int          mc_lat  = 5;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    icache #(.ENTRIES(256)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .addr_sgn(addr_sgn), .addr(addr),
        .flush(flush), .ins_sgn(ins_sgn), .ins(ins), .mc_req(mc_req),
        .mc_addr(mc_addr), .mc_done(mc_done), .mc_data(mc_data),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h0050_0093;
            32'h0000_0400: mem_word = 32'h0004_0013;
            32'h0000_0010: mem_word = 32'h0000_1013;
            default:       mem_word = 32'hdead_beef;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory controller model: answers mc_req after mc_lat cycles with a one-cycle mc_done.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        mc_done  = 1'b0;
        mc_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            mc_done = 1'b0;
            if (rst !== 1'b0 || mc_req !== 1'b1) begin
                wait_cnt = 0;
            end else begin
                wait_cnt++;
                if (wait_cnt == mc_lat) begin
                    mc_done  = 1'b1;
                    mc_data  = mem_word(mc_addr);
                    refills++;
                    wait_cnt = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && ins_sgn === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_ins: got pulse with %h, expected no pulse", ins);
            end else begin
                mon_exp = exp_q.pop_front();
                if (ins !== mon_exp) begin
                    n_err++;
                    $display("FAIL ins_data: got %h, expected %h", ins, mon_exp);
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp_ins, input bit exp_miss);
        bit saw_req;
        bit done;
        saw_req = 1'b0;
        done    = 1'b0;
        exp_q.push_back(exp_ins);
        addr     = a;
        addr_sgn = 1'b1;
        @(posedge clk);
        #1;
        if (exp_miss) check("miss_req_latency", {31'b0, mc_req}, 32'd1);
        else          check("hit_latency", {31'b0, ins_sgn}, 32'd1);
        for (int i = 0; i < 60 && !done; i++) begin
            if (mc_req === 1'b1 && !saw_req) begin
                saw_req = 1'b1;
                check("mc_addr", mc_addr, a);
            end
            if (ins_sgn === 1'b1) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        addr_sgn = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL fetch_timeout: got no ins_sgn for %h, expected a pulse", a);
        end
        check("refill_seen", {31'b0, saw_req}, {31'b0, exp_miss});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0;
        rst      = 1'b1;
        rdy      = 1'b1;
        addr_sgn = 1'b0;
        addr     = '0;
        flush    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ins_sgn", {31'b0, ins_sgn}, 32'd0);
        check("rst_ins", ins, 32'd0);
        check("rst_mc_req", {31'b0, mc_req}, 32'd0);
        check("rst_mc_addr", mc_addr, 32'd0);
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
        check("rst_state", {30'b0, dbg_state}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Cold miss then re-fetch hit
        fetch(32'h0000_0000, 32'h0050_0093, 1'b1);
        check("miss_cnt_cold", miss_cnt, (STAT != 0) ? 32'd1 : 32'd0);
        fetch(32'h0000_0000, 32'h0050_0093, 1'b0);
        check("hit_cnt_refetch", hit_cnt, (STAT != 0) ? 32'd1 : 32'd0);

        // Conflict on index 0: 0x400 evicts 0x000, which must refill again
        fetch(32'h0000_0400, 32'h0004_0013, 1'b1);
        fetch(32'h0000_0000, 32'h0050_0093, 1'b1);
        check("conflict_refills", refills, 32'd3);

        // Flush two cycles into a miss on 0x10
        r0       = refills;
        addr     = 32'h0000_0010;
        addr_sgn = 1'b1;
        @(posedge clk);
        #1;
        addr_sgn = 1'b0;
        check("flush_miss_req", {31'b0, mc_req}, 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        for (int i = 0; i < 40 && mc_req === 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        check("flush_req_until_done", refills, r0 + 1);
        check("flush_no_ins", {31'b0, ins_sgn}, 32'd0);
        check("flush_mc_addr", mc_addr, 32'h0000_0010);
        repeat (2) @(posedge clk);
        #1;
        fetch(32'h0000_0010, 32'h0000_1013, 1'b0);

        // Flush in the same cycle as a hit lookup
        addr     = 32'h0000_0000;
        addr_sgn = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        check("flush_beats_hit", {31'b0, ins_sgn}, 32'd0);
        addr_sgn = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        #1;

        // Held addr_sgn on a hitting address: pulses every other cycle
        repeat (4) exp_q.push_back(32'h0050_0093);
        addr     = 32'h0000_0000;
        addr_sgn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check("held_alternate", {31'b0, ins_sgn}, (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("frozen_ins_sgn", {31'b0, ins_sgn}, 32'd0);
            check("frozen_mc_req", {31'b0, mc_req}, 32'd0);
            check("frozen_mc_addr", mc_addr, 32'h0000_0010);
        end
        rdy = 1'b1;
        exp_q.push_back(32'h0050_0093);
        @(posedge clk);
        #1;
        check("resume_ins_sgn", {31'b0, ins_sgn}, 32'd1);
        addr_sgn = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check("final_hit_cnt", hit_cnt, (STAT != 0) ? 32'd7 : 32'd0);
        check("final_miss_cnt", miss_cnt, (STAT != 0) ? 32'd4 : 32'd0);
        check("exp_q_drained", exp_q.size(), 32'd0);
        check("total_refills", refills, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, one-word-per-line instruction cache between the instruction fetch stage and the memory controller. Takes the fetch PC and returns the 32-bit instruction word with a single-cycle valid pulse. On a miss it runs a word refill through the memory controller. In-flight results are discarded on a pipeline rollback.

## Interface
- `ENTRIES`, default 256: number of lines; power of two, ≥ 2. `IDX = log2(ENTRIES)`.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global ready; low freezes the block.
- `addr_sgn` in 1: fetch request valid (fetch stage not stalled).
- `addr` in 32: fetch PC, word-aligned.
- `flush` in 1: rollback from ROB; cancels any pending delivery.
- `ins_sgn` out 1: instruction valid; single-cycle pulse.
- `ins` out 32: instruction word; meaningful only while `ins_sgn` is high.
- `mc_req` out 1: refill request; held high until `mc_done`.
- `mc_addr` out 32: refill word address; stable while `mc_req` is high.
- `mc_done` in 1: refill complete; one-cycle pulse.
- `mc_data` in 32: refill word; valid with `mc_done`.
- `hit_cnt` out 32: lookup hit counter (see Configuration).
- `miss_cnt` out 32: lookup miss counter (see Configuration).

## Operation
- Address split: index = `addr[IDX+1:2]`; tag = `addr[31:IDX+2]`. Arrays: `valid[ENTRIES]`, `tag[ENTRIES]`, `data[ENTRIES]`. Only `valid` is reset (to 0).
- States: IDLE, MISS, DISCARD.
- IDLE: a lookup is accepted when `addr_sgn && !ins_sgn && !flush`. The `!ins_sgn` term blocks a duplicate lookup on the stale PC during the cycle in which fetch advances.
  - Hit: `ins <= data[idx]`, `ins_sgn <= 1`, stay in IDLE.
  - Miss: latch `miss_addr = addr`, `mc_addr <= addr`, `mc_req <= 1`, go to MISS.
- MISS:
  - On `mc_done`: write `data/tag/valid` at `miss_addr`'s index, `mc_req <= 0`, `ins <= mc_data`, `ins_sgn <= 1`, go to IDLE.
  - On `flush` without `mc_done`: go to DISCARD.
  - On `flush` with `mc_done`: fill the line, `ins_sgn` stays 0, go to IDLE.
- DISCARD: wait for `mc_done`, fill the line (the data is still correct), `ins_sgn` stays 0, `mc_req <= 0`, go to IDLE. `mc_req` is never withdrawn before `mc_done`.
- `flush` in any state forces `ins_sgn` to 0 on the next cycle. `flush` has priority over a same-cycle hit.
- `ins_sgn` defaults to 0 every cycle unless set by the rules above.
- `rdy` low: the state, arrays, `mc_req`, `mc_addr`, `ins` and the counters hold; `ins_sgn` is forced to 0. A delivery due in that cycle is lost, and fetch re-requests it.
- No self-modifying code: the cache is never invalidated except by `rst`.

## Timing
- Reset values: `ins_sgn` = 0, `ins` = 0, `mc_req` = 0, `mc_addr` = 0, counters = 0, state = IDLE, all `valid` = 0.
- Hit latency: `ins_sgn` goes high 1 cycle after the accepting edge.
- Throughput: one instruction every 2 cycles on consecutive hits.
- Miss latency: `mc_req` rises 1 cycle after lookup; `ins_sgn` rises 1 cycle after the `mc_done` cycle.
- `rst` mid-refill: return to IDLE and drop `mc_req`. The memory controller is reset by the same `rst`.
- A refill writing an index while a new lookup targets that same index cannot happen, because lookups occur only in IDLE.

## Configuration
- `ICACHE_STAT_EN` defined:
  - `hit_cnt` increments on each accepted lookup that hits.
  - `miss_cnt` increments on each accepted lookup that misses.
  - Both wrap modulo 2^32 and freeze with `rdy`.
- Not defined: `hit_cnt` and `miss_cnt` are tied to 0 and no counter registers are built.

## Test plan
- Cold miss: `addr` = 0x0000, `addr_sgn` = 1, memory answers 0x00500093 after 5 cycles → `mc_req` high with `mc_addr` = 0x0000; `ins_sgn` pulse with `ins` = 0x00500093 one cycle after `mc_done`; `miss_cnt` = 1.
- Re-fetch of 0x0000 → `ins_sgn` pulses 1 cycle later with 0x00500093; `mc_req` stays 0; `hit_cnt` = 1.
- Conflict with `ENTRIES` = 256: fetch 0x0000, then 0x0400, then 0x0000 → three refills; final data equals memory at 0x0000.
- `flush` asserted 2 cycles into a miss on 0x0010:
  - `mc_req` stays high until `mc_done` and no `ins_sgn` pulse appears.
  - A later fetch of 0x0010 then hits with no new `mc_req`.
- `flush` in the same cycle as a hit lookup → `ins_sgn` = 0 on the next cycle.
- Held `addr_sgn` with a constant `addr` on a hit:
  - `ins_sgn` alternates 1/0 with no back-to-back pulses.
  - With `rdy` = 0 for 3 cycles, `ins_sgn` = 0 and `mc_req`/`mc_addr` stay unchanged.
